// File: rtl/vga_capture_pkg.sv
// Shared constants, FSM encoding and window helper for the VGA frame-window capture block.
package vga_capture_pkg;

  // Visible area of the 640x480 source timing.
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FINISH  = 2'd3
  } state_e;

  // True when [start, start+size) lies inside [0, limit); 11-bit sum cannot wrap.
  function automatic logic win_fits(input logic [9:0] start, input logic [10:0] size,
                                    input logic [10:0] limit);
    return ({1'b0, start} + size) <= limit;
  endfunction

endpackage

// File: rtl/vga_capture_edge_det.sv
// Falling-edge detector: keeps a one-cycle registered copy of a level and flags 1 -> 0.
module vga_capture_edge_det #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic pclk,
  input  logic reset,
  input  logic sig,
  output logic fall
);

  logic sig_d;
  logic sig_q;

  // Next value of the copy is simply the current input level.
  always_comb sig_d = sig;

  // Registered copy; resets to the signal's idle level so no edge appears after reset.
  always_ff @(posedge pclk) begin
    if (reset) sig_q <= IDLE_LEVEL;
    else       sig_q <= sig_d;
  end

  assign fall = sig_q & ~sig;

endmodule

// File: rtl/vga_capture.sv
// Captures an IMG_W x IMG_H window of one VGA frame into a frame buffer, row-major.
module vga_capture #(
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int ADDR_W = 14
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              valid,
  input  logic [7:0]        vga_r,
  input  logic [7:0]        vga_g,
  input  logic [7:0]        vga_b,
  input  logic [9:0]        win_x,
  input  logic [9:0]        win_y,
  input  logic              arm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              error
);
  import vga_capture_pkg::*;

  localparam logic [10:0]       WIN_W     = 11'(IMG_W);
  localparam logic [10:0]       WIN_H     = 11'(IMG_H);
  localparam logic [10:0]       LIM_X     = 11'(H_ACTIVE);
  localparam logic [10:0]       LIM_Y     = 11'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  state_e            state_q, state_d;
  logic [9:0]        col_q, col_d;
  logic [9:0]        row_q, row_d;
  logic [9:0]        win_x_q, win_x_d;
  logic [9:0]        win_y_q, win_y_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              vs_fall;
  logic              valid_fall;
  logic              hs_fall_unused;
  logic [10:0]       x_end;
  logic [10:0]       y_end;
  logic              pix_hit;
  logic              arm_legal;

  // Sync edges come from registered copies; hsync is tracked but the line
  // boundary used by the counters is the valid falling edge.
  vga_capture_edge_det #(.IDLE_LEVEL(1'b1)) u_hsync_edge (
    .pclk(pclk), .reset(reset), .sig(hsync), .fall(hs_fall_unused)
  );
  vga_capture_edge_det #(.IDLE_LEVEL(1'b1)) u_vsync_edge (
    .pclk(pclk), .reset(reset), .sig(vsync), .fall(vs_fall)
  );
  vga_capture_edge_det #(.IDLE_LEVEL(1'b0)) u_valid_edge (
    .pclk(pclk), .reset(reset), .sig(valid), .fall(valid_fall)
  );

  // Column counts visible pixels in the line; row counts lines since vsync.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_fall)  col_d = '0;
    else if (valid)  col_d = col_q + 10'd1;
    if (vs_fall)          row_d = '0;
    else if (valid_fall)  row_d = row_q + 10'd1;
  end

  // Window membership of the pixel on the inputs this cycle, plus arm legality.
  always_comb begin
    x_end     = {1'b0, win_x_q} + WIN_W;
    y_end     = {1'b0, win_y_q} + WIN_H;
    pix_hit   = valid && (col_q >= win_x_q) && ({1'b0, col_q} < x_end)
                      && (row_q >= win_y_q) && ({1'b0, row_q} < y_end);
    arm_legal = win_fits(win_x, WIN_W, LIM_X) && win_fits(win_y, WIN_H, LIM_Y);
  end

  // Capture FSM: next state, write strobe/address/data, done and sticky error.
  always_comb begin
    state_d   = state_q;
    win_x_d   = win_x_q;
    win_y_d   = win_y_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    error_d   = error_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          win_x_d = win_x;
          win_y_d = win_y;
          error_d = 1'b0;
          if (arm_legal) begin
            state_d = ST_WAIT_VS;
          end else begin
            error_d = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      ST_WAIT_VS: begin
        if (vs_fall) begin
          state_d   = ST_CAPTURE;
          cnt_d     = '0;
          wr_addr_d = '0;
        end
      end
      ST_CAPTURE: begin
        if (pix_hit) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = {vga_r, vga_g, vga_b};
          cnt_d     = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST_ADDR) state_d = ST_FINISH;
        end
        // A new frame starting before the last write means the window was cut short.
        if (vs_fall && !(pix_hit && (cnt_q == LAST_ADDR))) begin
          error_d = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any capture silently.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      win_x_q   <= '0;
      win_y_q   <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      win_x_q   <= win_x_d;
      win_y_q   <= win_y_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench: randomized frames against a pixel-level model of window capture.
module tb_vga_capture;
  localparam int W = 8, H = 6, AW = 6, N = W * H;
  localparam int EV_BUSY1 = 0, EV_BUSY0 = 1, EV_ERR1 = 2, EV_ERR0 = 3,
                 EV_DONE = 4, EV_ADDR0 = 5, EV_RST = 6;

  logic pclk = 1'b0, reset = 1'b1, hsync = 1'b1, vsync = 1'b1, valid = 1'b0, arm = 1'b0;
  logic [7:0] vga_r = '0, vga_g = '0, vga_b = '0;
  logic [9:0] win_x = '0, win_y = '0;
  logic wr_en, busy, done, error;
  logic [AW-1:0] wr_addr;
  logic [23:0] wr_data;

  vga_capture #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .win_x(win_x), .win_y(win_y),
    .arm(arm), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  always #20 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int cyc; int kind; } ev_t;
  typedef struct { int cyc; int addr; logic [23:0] data; } wr_t;
  ev_t evq[$];
  wr_t wq[$];
  bit m_wait = 0, m_cap = 0;
  int m_cnt = 0, m_free = 0, m_wx = 0, m_wy = 0;

  // All model hooks are called right after inputs are driven; they take effect at cycle cyc+1.
  task automatic push_ev(input int c, input int k);
    ev_t e;
    e.cyc = c; e.kind = k;
    evq.push_back(e);
  endtask

  task automatic model_arm(input int wx, input int wy);
    int d;
    d = cyc + 1;
    if (!m_wait && !m_cap && d >= m_free) begin
      push_ev(d, EV_ERR0);
      if (wx + W <= 640 && wy + H <= 480) begin
        push_ev(d, EV_BUSY1);
        m_wait = 1; m_wx = wx; m_wy = wy;
      end else begin
        push_ev(d, EV_ERR1);
        push_ev(d, EV_DONE);
        m_free = d + 1;
      end
    end
  endtask

  task automatic model_end(input int d);
    push_ev(d + 1, EV_BUSY0);
    push_ev(d + 1, EV_DONE);
    m_cap = 0;
    m_free = d + 2;
  endtask

  task automatic model_vs_fall();
    int d;
    d = cyc + 1;
    if (m_wait) begin
      m_wait = 0; m_cap = 1; m_cnt = 0;
      push_ev(d, EV_ADDR0);
    end else if (m_cap) begin
      push_ev(d, EV_ERR1);
      model_end(d);
    end
  endtask

  task automatic model_pixel(input int r, input int c, input logic [23:0] rgb);
    wr_t w;
    int d;
    d = cyc + 1;
    if (m_cap && r >= m_wy && r < m_wy + H && c >= m_wx && c < m_wx + W) begin
      w.cyc = d; w.addr = m_cnt; w.data = rgb;
      wq.push_back(w);
      m_cnt++;
      if (m_cnt == N) model_end(d);
    end
  endtask

  task automatic model_reset(input int n);
    int d, i;
    d = cyc + 1;
    i = 0;
    while (i < evq.size()) if (evq[i].cyc >= d) evq.delete(i); else i++;
    i = 0;
    while (i < wq.size()) if (wq[i].cyc >= d) wq.delete(i); else i++;
    push_ev(d, EV_RST);
    m_wait = 0; m_cap = 0; m_free = d + n;
  endtask

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;
  logic exp_busy = 0, exp_err = 0, exp_done = 0;
  int exp_addr = 0, ci, n_wr = 0, last_addr = 0;
  logic [23:0] first_data = '0, last_data = '0;
  wr_t we;

  always @(negedge pclk) begin
    if (chk_en) begin
      exp_done = 1'b0;
      ci = 0;
      while (ci < evq.size()) begin
        if (evq[ci].cyc <= cyc) begin
          case (evq[ci].kind)
            EV_BUSY1: exp_busy = 1'b1;
            EV_BUSY0: exp_busy = 1'b0;
            EV_ERR1:  exp_err  = 1'b1;
            EV_ERR0:  exp_err  = 1'b0;
            EV_DONE:  exp_done = 1'b1;
            EV_ADDR0: exp_addr = 0;
            default: begin exp_busy = 1'b0; exp_err = 1'b0; exp_addr = 0; end
          endcase
          evq.delete(ci);
        end else ci++;
      end
      if (wr_en === 1'b1) begin
        if (wq.size() == 0) chk("wr_en_unexpected", 32'(wr_en), 32'd0);
        else begin
          we = wq.pop_front();
          chk("wr_latency_cycle", 32'(cyc), 32'(we.cyc));
          chk("wr_addr", 32'(wr_addr), 32'(we.addr));
          chk("wr_data", 32'(wr_data), 32'(we.data));
          exp_addr = we.addr;
          n_wr++;
          last_addr = we.addr;
          last_data = wr_data;
          if (we.addr == 0) first_data = wr_data;
        end
      end else begin
        if (wq.size() > 0 && wq[0].cyc <= cyc) begin
          chk("wr_en_missing", 32'(wr_en), 32'd1);
          void'(wq.pop_front());
        end
        chk("wr_addr_hold", 32'(wr_addr), 32'(exp_addr));
      end
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("error", 32'(error), 32'(exp_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic vs, input logic hs,
                       input logic [23:0] rgb, input logic a);
    @(negedge pclk);
    valid = v; vsync = vs; hsync = hs; {vga_r, vga_g, vga_b} = rgb; arm = a;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b1, 1'b1, 24'h0, 1'b0);
  endtask

  task automatic do_arm(input int wx, input int wy);
    win_x = 10'(wx); win_y = 10'(wy);
    drive(1'b0, 1'b1, 1'b1, 24'h0, 1'b1);
    model_arm(wx, wy);
    idle(1);
  endtask

  task automatic do_reset(input int n);
    @(negedge pclk);
    reset = 1'b1; valid = 1'b0; arm = 1'b0; vsync = 1'b1; hsync = 1'b1;
    model_reset(n);
    repeat (n - 1) @(negedge pclk);
    @(negedge pclk);
    reset = 1'b0;
  endtask

  task automatic vsync_pulse();
    drive(1'b0, 1'b0, 1'b1, 24'h0, 1'b0);
    model_vs_fall();
    drive(1'b0, 1'b0, 1'b1, 24'h0, 1'b0);
    idle(2);
  endtask

  // One frame: short lines outside the window rows, full-width-enough lines inside.
  task automatic send_frame(input int wx, input int wy, input int nlines,
                            input int arm2_line, input int rst_after, input bit pins);
    vsync_pulse();
    for (int r = 0; r < nlines; r++) begin
      int len;
      if (r >= wy && r < wy + H) len = wx + W + int'($urandom_range(0, 3));
      else                       len = int'($urandom_range(1, 3));
      if (len > 640) len = 640;
      for (int c = 0; c < len; c++) begin
        logic [23:0] rgb;
        rgb = 24'($urandom);
        if (pins && r == wy && c == wx) rgb = 24'h123456;
        if (pins && r == wy + H - 1 && c == wx + W - 1) rgb = 24'hABCDEF;
        drive(1'b1, 1'b1, 1'b1, rgb, 1'b0);
        model_pixel(r, c, rgb);
        if (rst_after > 0 && m_cap && m_cnt == rst_after) begin
          idle(1);
          do_reset(3);
          return;
        end
      end
      drive(1'b0, 1'b1, 1'b0, 24'h0, 1'b0);
      if (r == arm2_line) begin
        win_x = 10'd633; win_y = 10'd0;
        drive(1'b0, 1'b1, 1'b1, 24'h0, 1'b1);
        model_arm(633, 0);
      end else begin
        drive(1'b0, 1'b1, 1'b1, 24'h0, 1'b0);
      end
    end
  endtask

  int base, wx, wy, nl;

  initial begin
    repeat (3) @(negedge pclk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    chk_en = 1;
    idle(3);

    // Clean capture with pinned first/last pixels.
    base = n_wr;
    do_arm(200, 200);
    send_frame(200, 200, 208, -1, -1, 1'b1);
    idle(4);
    chk("s1_writes", 32'(n_wr - base), 32'd48);
    chk("s1_first_data", 32'(first_data), 32'h123456);
    chk("s1_last_addr", 32'(last_addr), 32'd47);
    chk("s1_last_data", 32'(last_data), 32'hABCDEF);
    chk("s1_error", 32'(error), 32'd0);

    // Illegal windows: immediate error and done, no writes, never busy.
    base = n_wr;
    do_arm(633, 0);
    idle(2);
    chk("ill_x_error", 32'(error), 32'd1);
    chk("ill_x_busy", 32'(busy), 32'd0);
    do_arm(0, 475);
    idle(2);
    chk("ill_y_error", 32'(error), 32'd1);
    chk("ill_writes", 32'(n_wr - base), 32'd0);

    // Truncated frame: vsync arrives after only 3 window lines.
    base = n_wr;
    do_arm(0, 470);
    send_frame(0, 470, 473, -1, -1, 1'b0);
    vsync_pulse();
    idle(4);
    chk("trunc_error", 32'(error), 32'd1);
    chk("trunc_writes", 32'(n_wr - base), 32'd24);

    // Bottom-right corner window.
    base = n_wr;
    do_arm(632, 474);
    send_frame(632, 474, 480, -1, -1, 1'b0);
    idle(4);
    chk("br_writes", 32'(n_wr - base), 32'd48);
    chk("br_last_addr", 32'(last_addr), 32'd47);
    chk("br_error", 32'(error), 32'd0);

    // Random windows (some may be illegal; the model decides).
    for (int k = 0; k < 3; k++) begin
      wx = int'($urandom_range(0, 640));
      wy = int'($urandom_range(0, 480));
      nl = (wy + H + 1 > 480) ? 480 : wy + H + 1;
      do_arm(wx, wy);
      send_frame(wx, wy, nl, -1, -1, 1'b0);
      idle(4);
    end

    // Ignored second arm during capture, then reset after 20 writes.
    do_arm(100, 10);
    send_frame(100, 10, 20, 11, 20, 1'b0);
    chk("prst_wr_en", 32'(wr_en), 32'd0);
    chk("prst_wr_addr", 32'(wr_addr), 32'd0);
    chk("prst_wr_data", 32'(wr_data), 32'd0);
    chk("prst_busy", 32'(busy), 32'd0);
    chk("prst_done", 32'(done), 32'd0);
    chk("prst_error", 32'(error), 32'd0);
    idle(3);

    // Recovery capture after reset.
    base = n_wr;
    do_arm(37, 5);
    send_frame(37, 5, 12, -1, -1, 1'b0);
    idle(4);
    chk("rec_writes", 32'(n_wr - base), 32'd48);
    chk("pending_writes", 32'(wq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
